// File: rtl/fnd_digit_scanner.sv
// fnd_digit_scanner: multiplexed 7-segment digit scanner with blanking, mask and PWM brightness
module fnd_digit_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 100000,
  parameter int BLANK_CYCLES = 16,
  localparam int POS_W = $clog2(NUM_DIGITS),
  localparam int CNT_W = $clog2(SCAN_DIV)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [NUM_DIGITS-1:0] i_blank_mask,
  input  logic [3:0]            i_brightness,
  output logic [NUM_DIGITS-1:0] o_digit,
  output logic [POS_W-1:0]      o_digitPosition,
  output logic                  o_scan_tick,
  output logic                  o_frame_start
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d, pos_o_q, pos_o_d;
  logic [3:0] pwm_q, pwm_d;
  logic [NUM_DIGITS-1:0] digit_q, digit_d;
  logic tick_q, tick_d, frame_q, frame_d, last, lit;
  // counters advance on enabled clocks; outputs for the slot cycle being counted are registered together
  always_comb begin
    last = cnt_q == CNT_W'(SCAN_DIV - 1);
    cnt_d = !i_enable ? cnt_q : last ? '0 : cnt_q + 1'b1;
    pos_d = (!i_enable || !last) ? pos_q : pos_q == POS_W'(NUM_DIGITS - 1) ? '0 : pos_q + 1'b1;
    pwm_d = !i_enable ? pwm_q : pwm_q == 4'd14 ? 4'd0 : pwm_q + 4'd1;
    lit = i_enable && (({1'b0, cnt_q} + 1'b1) > (CNT_W + 1)'(BLANK_CYCLES))
          && !i_blank_mask[pos_q] && (pwm_q < i_brightness);
    digit_d = lit ? ~(NUM_DIGITS'(1) << pos_q) : '1;
    pos_o_d = pos_q;
    tick_d = i_enable && last;
    frame_d = i_enable && cnt_q == '0 && pos_q == '0;
  end
  // state and output registers; reset aborts any slot and darkens the display
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
      pos_q <= '0;
      pwm_q <= '0;
      digit_q <= '1;
      pos_o_q <= '0;
      tick_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      pwm_q <= pwm_d;
      digit_q <= digit_d;
      pos_o_q <= pos_o_d;
      tick_q <= tick_d;
      frame_q <= frame_d;
    end
  end
  assign o_digit = digit_q;
  assign o_digitPosition = pos_o_q;
  assign o_scan_tick = tick_q;
  assign o_frame_start = frame_q;
endmodule
